// File: rtl/alu_md_unit.sv
// ALU with an iterative multiply/divide unit and HI/LO result registers.
// Single-cycle operations and MFHI/MFLO are decoded combinationally; MULTU
// and DIVU run for WIDTH cycles in a small FSM and update HI/LO at the end.
module alu_md_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] Output,
    output logic             Zero,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor
    logic [WIDTH-1:0]   work_hi_q, work_hi_d; // partial product high / remainder
    logic [WIDTH-1:0]   work_lo_q, work_lo_d; // multiplier bits / dividend->quotient
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_r, is_multu, is_divu, is_mfhi, is_mflo;
    logic               slt;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result;

    assign is_r     = (ALUop == 2'b10);
    assign is_multu = is_r && (funct == F_MULTU);
    assign is_divu  = is_r && (funct == F_DIVU);
    assign is_mfhi  = is_r && (funct == F_MFHI);
    assign is_mflo  = is_r && (funct == F_MFLO);
    assign slt      = ($signed(dataA) < $signed(dataB));
    assign shamt    = dataB[SHAMT_W-1:0];

    // Combinational result decode; MULTU/DIVU and unknown codes yield zero.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        result = '0;
        case (ALUop)
            2'b00: result = dataA + dataB;
            2'b01: result = dataA - dataB;
            2'b11: result = {{(WIDTH-1){1'b0}}, slt};
            default: begin
                case (funct)
                    F_AND:  result = dataA & dataB;
                    F_OR:   result = dataA | dataB;
                    F_ADD:  result = dataA + dataB;
                    F_SUB:  result = dataA - dataB;
                    F_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
                    F_SLL:  result = dataA << shamt;
                    F_SRL:  result = dataA >> shamt;
                    F_MFHI: result = hi_q;
                    F_MFLO: result = lo_q;
                    default: result = '0;
                endcase
            end
        endcase
    end

    assign Output = result;
    assign Zero   = (result == '0);
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign stall  = busy && valid && (is_multu || is_divu || is_mfhi || is_mflo);

    // One shift-add multiply step and one restoring-divide step, from current state.
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        mul_addend = work_lo_q[0] ? opnd_q : '0;
        mul_sum    = {1'b0, work_hi_q} + {1'b0, mul_addend};
        div_sh     = {work_hi_q, work_lo_q[WIDTH-1]};
        div_ge     = (div_sh >= {1'b0, opnd_q});
        div_diff   = div_sh[WIDTH-1:0] - opnd_q;
    end

    // Next-state logic: operand capture in IDLE, one iteration per cycle otherwise.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid && is_multu) begin
                    state_d   = MUL;
                    cnt_d     = '0;
                    opnd_d    = dataA;
                    work_hi_d = '0;
                    work_lo_d = dataB;
                end else if (valid && is_divu) begin
                    state_d   = DIV;
                    cnt_d     = '0;
                    opnd_d    = dataB;
                    work_hi_d = '0;
                    work_lo_d = dataA;
                end
            end
            MUL: begin
                work_hi_d = mul_sum[WIDTH:1];
                work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                cnt_d     = cnt_q + SHAMT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    hi_d    = work_hi_d;
                    lo_d    = work_lo_d;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DIV: begin
                // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
                work_hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
                work_lo_d = {work_lo_q[WIDTH-2:0], div_ge};
                cnt_d     = cnt_q + SHAMT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    hi_d    = work_hi_d;
                    lo_d    = work_lo_d;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_md_unit.sv
// Randomised self-checking bench for alu_md_unit against a behavioural model.
module tb_alu_md_unit;

    localparam int W = 32;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [1:0]   ALUop;
    logic [5:0]   funct;
    logic [W-1:0] dataA, dataB;
    logic [W-1:0] Output;
    logic         Zero, busy, stall, done;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the architectural HI/LO registers.
    logic [W-1:0] exp_hi, exp_lo;

    alu_md_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .valid(valid), .ALUop(ALUop), .funct(funct),
        .dataA(dataA), .dataB(dataB), .Output(Output), .Zero(Zero),
        .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                             input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] hi, input logic [W-1:0] lo);
        int sa;
        sa = int'(b % 32);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        case (f)
            F_AND:  return a & b;
            F_OR:   return a | b;
            F_ADD:  return a + b;
            F_SUB:  return a - b;
            F_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            F_SLL:  return a << sa;
            F_SRL:  return a >> sa;
            F_MFHI: return hi;
            F_MFLO: return lo;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one operation combinationally and compare Output/Zero to the model.
    task automatic alu_case(input string tag, input logic [1:0] op, input logic [5:0] f,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] e;
        ALUop = op; funct = f; dataA = a; dataB = b;
        #1;
        e = ref_alu(op, f, a, b, exp_hi, exp_lo);
        check({tag, "_out"}, 64'(Output), 64'(e));
        check({tag, "_zero"}, 64'(Zero), 64'(e == 0));
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    task automatic check_hilo(input string tag);
        valid = 1'b0; ALUop = 2'b10;
        funct = F_MFHI; #1;
        check({tag, "_hi"}, 64'(Output), 64'(exp_hi));
        funct = F_MFLO; #1;
        check({tag, "_lo"}, 64'(Output), 64'(exp_lo));
    endtask

    task automatic model_md(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        if (op == F_MULTU) begin
            p = longint'(a) * longint'(b);
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b == 0) begin
            exp_hi = a;
            exp_lo = '1;
        end else begin
            exp_hi = a % b;
            exp_lo = a / b;
        end
    endtask

    // Issue a MULTU/DIVU, run it to completion and check timing and HI/LO.
    // Leaves the bench inside the done cycle.
    task automatic run_md(input string tag, input logic [5:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc;
        ALUop = 2'b10; funct = op; dataA = a; dataB = b; valid = 1'b1;
        #1;
        check({tag, "_issue_out"}, 64'(Output), 64'd0);
        check({tag, "_issue_zero"}, 64'(Zero), 64'd1);
        tick();
        valid = 1'b0;
        wait_idle(cyc);
        check({tag, "_busy_cycles"}, 64'(cyc), 64'd32);
        check({tag, "_done"}, 64'(done), 64'd1);
        model_md(op, a, b);
        check_hilo(tag);
    endtask

    initial begin
        int cyc;
        logic [5:0] codes [12];
        logic [1:0] op;
        logic [5:0] f;
        logic [W-1:0] a, b;
        logic [5:0] mop;

        codes = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_SRL,
                  F_MULTU, F_DIVU, F_MFHI, F_MFLO, 6'b111111};
        exp_hi = '0; exp_lo = '0;

        // Reset state, with an MD request presented while held in reset.
        rst = 1'b0; valid = 1'b1; ALUop = 2'b10; funct = F_MULTU; dataA = 5; dataB = 6;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        funct = F_MFLO; #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_mflo", 64'(Output), 64'd0);
        funct = F_MFHI; #1;
        check("rst_mfhi", 64'(Output), 64'd0);
        valid = 1'b0;
        tick();
        rst = 1'b1;

        // Directed single-cycle cases.
        alu_case("add_wrap", 2'b10, F_ADD, 32'hFFFF_FFFF, 32'h1);
        check("add_wrap_busy", 64'(busy), 64'd0);
        alu_case("slt_neg", 2'b10, F_SLT, 32'hFFFF_FFFE, 32'h1);
        alu_case("srl_31", 2'b10, F_SRL, 32'h8000_0000, 32'h1F);
        alu_case("sll_trunc", 2'b10, F_SLL, 32'h0000_0003, 32'h21);
        alu_case("aluop_sub", 2'b01, F_AND, 32'h5, 32'h7);
        alu_case("aluop_slt", 2'b11, F_OR, 32'h7FFF_FFFF, 32'h8000_0000);
        alu_case("bad_funct", 2'b10, 6'b111111, 32'h1234, 32'h1);

        // Randomised single-cycle ops, valid toggled where it cannot start an MD op.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            f  = codes[$urandom_range(0, 11)];
            a  = $urandom; b = $urandom;
            if (i % 5 == 0) b = a;
            valid = (op == 2'b10 && (f == F_MULTU || f == F_DIVU)) ? 1'b0 : 1'($urandom % 2);
            alu_case("rand_alu", op, f, a, b);
            tick();
        end
        valid = 1'b0;

        // Multiply and divide directed cases.
        run_md("mul_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        check("mul_max_done_drop", 64'(done), 64'd0);
        run_md("div_100_7", F_DIVU, 32'd100, 32'd7);
        // Back-to-back: issued in the done cycle.
        run_md("div_by_0", F_DIVU, 32'd5, 32'd0);
        tick();

        // Random back-to-back multiply/divide sequence.
        for (int i = 0; i < 6; i++) begin
            mop = ($urandom % 2) ? F_MULTU : F_DIVU;
            a = $urandom;
            b = ($urandom % 4 == 0) ? 32'd0 : (($urandom % 2) ? $urandom : 32'($urandom_range(1, 1000)));
            run_md("rand_md", mop, a, b);
        end
        tick();
        check("rand_md_done_drop", 64'(done), 64'd0);

        // Stall behaviour during a multiply.
        run_md("pre_stall", F_MULTU, 32'd7, 32'd9);
        tick();
        ALUop = 2'b10; funct = F_MULTU; dataA = 32'h1234_5678; dataB = 32'h9ABC_DEF0; valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        valid = 1'b1; funct = F_MFLO; #1;
        check("stall_mflo", 64'(stall), 64'd1);
        check("stall_mflo_old", 64'(Output), 64'(exp_lo));
        funct = F_MFHI; #1;
        check("stall_mfhi_old", 64'(Output), 64'(exp_hi));
        tick();
        funct = F_MULTU; dataA = 32'hFFFF_0000; dataB = 32'h0000_FFFF; #1;
        check("stall_multu", 64'(stall), 64'd1);
        tick();
        tick();
        funct = F_ADD; dataA = 32'h0000_1111; dataB = 32'h0000_2222; #1;
        check("busy_add_stall", 64'(stall), 64'd0);
        check("busy_add_out", 64'(Output), 64'h3333);
        valid = 1'b0;
        wait_idle(cyc);
        check("stall_busy_rest", 64'(cyc), 64'd26);
        check("stall_done", 64'(done), 64'd1);
        model_md(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        check_hilo("stall_result");
        tick();

        // Reset asserted during the 10th multiply iteration.
        ALUop = 2'b10; funct = F_MULTU; dataA = 32'hDEAD_BEEF; dataB = 32'hCAFE_BABE; valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (9) tick();
        check("pre_abort_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        exp_hi = '0; exp_lo = '0;
        check_hilo("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 64'(done), 64'd0);
        end
        rst = 1'b1;
        run_md("post_rst_mul", F_MULTU, 32'd3, 32'd4);
        tick();
        check("final_done_drop", 64'(done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
